regfile_bank: RTL and testbench

Parametrised, clocked general-purpose register bank for the CPU datapath, successor to the combinational one-hot-enable register set. It takes one binary-addressed write port and two registered read ports, and keeps a per-register pending scoreboard so the decode stage can stall on registers whose load result has not yet returned. It sits between the load/ALU result mux (write side) and operand fetch (read side).

---
 rtl/regfile_pkg.sv | 11 +
 rtl/regfile_read_port.sv | 67 ++++++
 rtl/regfile_bank.sv | 111 +++++++++++
 tb/tb_regfile_bank.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// Shared defaults for the register bank: word width, register count and address type.
// The same-cycle write-to-read bypass is enabled with the REGFILE_BYPASS_EN macro.
package regfile_pkg;

  localparam int unsigned DEFAULT_DATA_W   = 32;
  localparam int unsigned DEFAULT_NUM_REGS = 16;
  localparam int unsigned DEFAULT_ADDR_W   = $clog2(DEFAULT_NUM_REGS);

  typedef logic [DEFAULT_ADDR_W-1:0] addr_t;

endpackage

// File: rtl/regfile_read_port.sv
// One registered read port: range check, optional write bypass, and output registers.
// With REGFILE_BYPASS_EN defined, a read colliding with a same-cycle write returns wr_data.
module regfile_read_port
  import regfile_pkg::*;
#(
  parameter int unsigned DATA_W   = DEFAULT_DATA_W,
  parameter int unsigned NUM_REGS = DEFAULT_NUM_REGS,
  parameter int unsigned ADDR_W   = $clog2(NUM_REGS)
) (
  input  logic              clk,
  input  logic              reset_n,
`ifdef REGFILE_BYPASS_EN
  // Write and lock strobes arrive already range-qualified from the bank.
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              lock_en,
  input  logic [ADDR_W-1:0] lock_addr,
`endif
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  input  logic [DATA_W-1:0] regs [NUM_REGS],
  input  logic [NUM_REGS-1:0] pending,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_stall
);

  localparam logic [ADDR_W:0] NumRegsW = (ADDR_W + 1)'(NUM_REGS);

  logic              addr_ok;
  logic [DATA_W-1:0] data_d, data_q;
  logic              stall_d, stall_q;

  assign addr_ok = ({1'b0, rd_addr} < NumRegsW);

  // Select the word and pending bit for the addressed register; out-of-range reads give 0/0.
  always_comb begin
    data_d  = '0;
    stall_d = 1'b0;
    if (addr_ok) begin
      data_d  = regs[rd_addr];
      stall_d = pending[rd_addr];
`ifdef REGFILE_BYPASS_EN
      if (wr_en && (wr_addr == rd_addr)) begin
        data_d  = wr_data;
        // The write clears pending unless a lock to the same register lands too.
        stall_d = lock_en && (lock_addr == rd_addr);
      end
`endif
    end
  end

  // Output registers update only on an enabled read and hold otherwise.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      data_q  <= '0;
      stall_q <= 1'b0;
    end else if (rd_en) begin
      data_q  <= data_d;
      stall_q <= stall_d;
    end
  end

  assign rd_data  = data_q;
  assign rd_stall = stall_q;

endmodule

// File: rtl/regfile_bank.sv
// General-purpose register bank: one write port, two registered read ports, and a
// per-register pending scoreboard for load-use stalls. Same-cycle write-to-read
// bypass is enabled with the REGFILE_BYPASS_EN macro.
module regfile_bank
  import regfile_pkg::*;
#(
  parameter int unsigned DATA_W   = DEFAULT_DATA_W,
  parameter int unsigned NUM_REGS = DEFAULT_NUM_REGS,
  parameter int unsigned ADDR_W   = $clog2(NUM_REGS)
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                wr_en,
  input  logic [ADDR_W-1:0]   wr_addr,
  input  logic [DATA_W-1:0]   wr_data,
  input  logic                lock_en,
  input  logic [ADDR_W-1:0]   lock_addr,
  input  logic                rd_en_a,
  input  logic [ADDR_W-1:0]   rd_addr_a,
  output logic [DATA_W-1:0]   rd_data_a,
  output logic                rd_stall_a,
  input  logic                rd_en_b,
  input  logic [ADDR_W-1:0]   rd_addr_b,
  output logic [DATA_W-1:0]   rd_data_b,
  output logic                rd_stall_b,
  output logic [NUM_REGS-1:0] pending
);

  localparam logic [ADDR_W:0] NumRegsW = (ADDR_W + 1)'(NUM_REGS);

  logic [DATA_W-1:0]   regs_q [NUM_REGS];
  logic [NUM_REGS-1:0] pending_d, pending_q;
  logic                wr_ok, lock_ok;

  // Out-of-range writes and locks are dropped (only possible for non-power-of-2 sizes).
  assign wr_ok   = wr_en   && ({1'b0, wr_addr}   < NumRegsW);
  assign lock_ok = lock_en && ({1'b0, lock_addr} < NumRegsW);

  // Scoreboard next state: a write clears pending, a lock sets it; lock applied last wins.
  always_comb begin
    pending_d = pending_q;
    if (wr_ok) begin
      pending_d[wr_addr] = 1'b0;
    end
    if (lock_ok) begin
      pending_d[lock_addr] = 1'b1;
    end
  end

  // Storage array and scoreboard state.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < int'(NUM_REGS); i++) begin
        regs_q[i] <= '0;
      end
      pending_q <= '0;
    end else begin
      if (wr_ok) begin
        regs_q[wr_addr] <= wr_data;
      end
      pending_q <= pending_d;
    end
  end

  assign pending = pending_q;

  regfile_read_port #(
    .DATA_W   (DATA_W),
    .NUM_REGS (NUM_REGS),
    .ADDR_W   (ADDR_W)
  ) u_port_a (
    .clk       (clk),
    .reset_n   (reset_n),
`ifdef REGFILE_BYPASS_EN
    .wr_en     (wr_ok),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .lock_en   (lock_ok),
    .lock_addr (lock_addr),
`endif
    .rd_en     (rd_en_a),
    .rd_addr   (rd_addr_a),
    .regs      (regs_q),
    .pending   (pending_q),
    .rd_data   (rd_data_a),
    .rd_stall  (rd_stall_a)
  );

  regfile_read_port #(
    .DATA_W   (DATA_W),
    .NUM_REGS (NUM_REGS),
    .ADDR_W   (ADDR_W)
  ) u_port_b (
    .clk       (clk),
    .reset_n   (reset_n),
`ifdef REGFILE_BYPASS_EN
    .wr_en     (wr_ok),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .lock_en   (lock_ok),
    .lock_addr (lock_addr),
`endif
    .rd_en     (rd_en_b),
    .rd_addr   (rd_addr_b),
    .regs      (regs_q),
    .pending   (pending_q),
    .rd_data   (rd_data_b),
    .rd_stall  (rd_stall_b)
  );

endmodule

// File: tb/tb_regfile_bank.sv
// Directed bench for regfile_bank: a reference model predicts each read when it is issued,
// the prediction is queued, and it is popped and compared once the read result is registered.
module tb_regfile_bank;
  import regfile_pkg::*;

  localparam int unsigned DW = DEFAULT_DATA_W;
  localparam int unsigned NR = DEFAULT_NUM_REGS;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          wr_en, lock_en, rd_en_a, rd_en_b;
  addr_t         wr_addr, lock_addr, rd_addr_a, rd_addr_b;
  logic [DW-1:0] wr_data;
  logic [DW-1:0] rd_data_a, rd_data_b;
  logic          rd_stall_a, rd_stall_b;
  logic [NR-1:0] pending;

  regfile_bank dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .lock_en    (lock_en),
    .lock_addr  (lock_addr),
    .rd_en_a    (rd_en_a),
    .rd_addr_a  (rd_addr_a),
    .rd_data_a  (rd_data_a),
    .rd_stall_a (rd_stall_a),
    .rd_en_b    (rd_en_b),
    .rd_addr_b  (rd_addr_b),
    .rd_data_b  (rd_data_b),
    .rd_stall_b (rd_stall_b),
    .pending    (pending)
  );

  always #5 clk = ~clk;

  // Reference model state.
  logic [DW-1:0] m_regs [NR];
  logic [NR-1:0] m_pend;
  logic [DW:0]   q_a [$];
  logic [DW:0]   q_b [$];
  logic [DW:0]   last_a;

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Predict a read from the model plus whatever write/lock is driven in the same cycle.
  task automatic predict(input addr_t a, output logic [DW:0] e);
    e = {m_pend[a], m_regs[a]};
`ifdef REGFILE_BYPASS_EN
    if (wr_en && wr_addr == a) e = {lock_en && lock_addr == a, wr_data};
`endif
  endtask

  // Queue predictions for this cycle's reads, update the model, clock, then score.
  task automatic tick();
    logic [DW:0] e;
    if (rd_en_a) begin predict(rd_addr_a, e); q_a.push_back(e); end
    if (rd_en_b) begin predict(rd_addr_b, e); q_b.push_back(e); end
    if (wr_en) begin m_regs[wr_addr] = wr_data; m_pend[wr_addr] = 1'b0; end
    if (lock_en) m_pend[lock_addr] = 1'b1;
    @(posedge clk);
    #1;
    wr_en = 1'b0; lock_en = 1'b0; rd_en_a = 1'b0; rd_en_b = 1'b0;
    if (q_a.size() > 0) begin
      e = q_a.pop_front();
      check("rd_data_a", rd_data_a, e[DW-1:0]);
      check("rd_stall_a", 32'(rd_stall_a), 32'(e[DW]));
      last_a = e;
    end
    if (q_b.size() > 0) begin
      e = q_b.pop_front();
      check("rd_data_b", rd_data_b, e[DW-1:0]);
      check("rd_stall_b", 32'(rd_stall_b), 32'(e[DW]));
    end
  endtask

  task automatic do_write(input addr_t a, input logic [DW-1:0] d);
    wr_en = 1'b1; wr_addr = a; wr_data = d;
  endtask

  task automatic do_lock(input addr_t a);
    lock_en = 1'b1; lock_addr = a;
  endtask

  task automatic read_a(input addr_t a);
    rd_en_a = 1'b1; rd_addr_a = a;
  endtask

  task automatic read_b(input addr_t a);
    rd_en_b = 1'b1; rd_addr_b = a;
  endtask

  task automatic model_reset();
    for (int i = 0; i < int'(NR); i++) m_regs[i] = '0;
    m_pend = '0;
  endtask

  initial begin
    reset_n = 1'b0;
    wr_en = 1'b0; lock_en = 1'b0; rd_en_a = 1'b0; rd_en_b = 1'b0;
    wr_addr = '0; lock_addr = '0; rd_addr_a = '0; rd_addr_b = '0; wr_data = '0;
    last_a = '0;
    model_reset();

    // Reset state.
    repeat (2) @(posedge clk);
    #1;
    check("reset rd_data_a", rd_data_a, '0);
    check("reset rd_stall_b", 32'(rd_stall_b), 32'd0);
    check("reset pending", 32'(pending), 32'd0);
    reset_n = 1'b1;

    // Read every register on both ports (B walks downwards).
    for (int i = 0; i < int'(NR); i++) begin
      read_a(addr_t'(i));
      read_b(addr_t'(NR - 1 - i));
      tick();
    end
    check("pending after sweep", 32'(pending), 32'h0000);

    // Write then read on the next cycle.
    do_write(4'd5, 32'hDEADBEEF); tick();
    read_a(4'd5); tick();
    check("r5 literal", rd_data_a, 32'hDEADBEEF);

    // Output holds while read enable is low, even if the register changes.
    do_write(4'd5, 32'h0BADF00D); tick();
    check("hold rd_data_a", rd_data_a, last_a[DW-1:0]);

    // Lock, then stall visible on the next read; a write clears it.
    do_lock(4'd3); tick();
    check("pending after lock r3", 32'(pending), 32'(m_pend));
    check("pending[3] literal", 32'(pending[3]), 32'd1);
    read_b(4'd3); tick();
    do_write(4'd3, 32'h1234); tick();
    read_b(4'd3); tick();
    check("r3 after write", rd_data_b, 32'h1234);

    // Same-cycle write and read of r7.
    do_write(4'd7, 32'h1); tick();
    do_write(4'd7, 32'hA5A5A5A5); read_a(4'd7); tick();
`ifdef REGFILE_BYPASS_EN
    check("r7 bypass", rd_data_a, 32'hA5A5A5A5);
`else
    check("r7 no bypass", rd_data_a, 32'h1);
`endif
    read_a(4'd7); tick();

    // Same-cycle write and lock of r9: lock wins, data lands; both ports on one address.
    do_write(4'd9, 32'h99998888); do_lock(4'd9); tick();
    check("pending after wr+lock r9", 32'(pending), 32'(m_pend));
    read_a(4'd9); read_b(4'd9); tick();

    // Same-cycle write, lock and read of r4.
    do_write(4'd4, 32'h44440000); tick();
    do_write(4'd4, 32'h4444FFFF); do_lock(4'd4); read_a(4'd4); read_b(4'd6); do_lock(4'd6);
    tick();

    // Fill all registers, lock r2, then reset mid-stream with reads in flight.
    for (int i = 0; i < int'(NR); i++) begin
      do_write(addr_t'(i), 32'h1111_1111 * (i + 1));
      tick();
    end
    do_lock(4'd2); read_a(4'd2); tick();
    read_a(4'd5); read_b(4'd2);
    #2 reset_n = 1'b0;
    #1;
    check("async rst rd_data_a", rd_data_a, '0);
    check("async rst rd_stall_a", 32'(rd_stall_a), 32'd0);
    check("async rst rd_data_b", rd_data_b, '0);
    check("async rst pending", 32'(pending), 32'd0);
    @(posedge clk);
    #1;
    check("in-reset rd_data_b", rd_data_b, '0);
    reset_n = 1'b1;
    rd_en_a = 1'b0; rd_en_b = 1'b0;
    model_reset();
    read_a(4'd2); tick();
    check("r2 after reset", rd_data_a, 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
